// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads the word at the PC address over a req/ack
// memory port and holds it, with its decoded fields, for decode/control.
module instruction_fetch #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 16,
  parameter int                 TIMEOUT   = 15,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  instructionAddress,
  input  logic               consume,
  input  logic               flush,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         op,
  output logic [3:0]         da,
  output logic [3:0]         aa,
  output logic [3:0]         ba,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic               fetch_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, REQ, HOLD} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t             state, state_nx;
  logic               mem_req_nx;
  logic [ADDR_W-1:0]  mem_addr_nx;
  logic               instr_valid_nx;
  logic [INSTR_W-1:0] instr_nx;
  logic [ADDR_W-1:0]  instr_addr_nx;
  logic               fetch_err_nx;
  logic [7:0]         tmo_cnt, tmo_cnt_nx;
  logic               discard, discard_nx;
  logic               drop_data;

  // A flush in the same cycle as the ack or the timeout drops the word too.
  assign drop_data = discard || flush;

  // NOTE: every signal written here gets its hold value first, so a branch
  // that forgets an assignment cannot infer a latch.
  always_comb begin
    state_nx       = state;
    mem_req_nx     = mem_req;
    mem_addr_nx    = mem_addr;
    instr_valid_nx = instr_valid;
    instr_nx       = instr;
    instr_addr_nx  = instr_addr;
    fetch_err_nx   = fetch_err;
    tmo_cnt_nx     = tmo_cnt;
    discard_nx     = discard;

    unique case (state)
      IDLE: state_nx = ISSUE;

      ISSUE: begin
        mem_addr_nx = instructionAddress;
        tmo_cnt_nx  = '0;
        discard_nx  = 1'b0;
        mem_req_nx  = 1'b1;
        state_nx    = REQ;
      end

      REQ: begin
        if (mem_ack) begin
          mem_req_nx = 1'b0;
          if (drop_data) begin
            state_nx = ISSUE;
          end else begin
            instr_nx       = mem_rdata;
            instr_addr_nx  = mem_addr;
            instr_valid_nx = 1'b1;
            state_nx       = HOLD;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          mem_req_nx   = 1'b0;
          fetch_err_nx = 1'b1;
          if (drop_data) begin
            state_nx = ISSUE;
          end else begin
            instr_nx       = NOP_INSTR;
            instr_addr_nx  = mem_addr;
            instr_valid_nx = 1'b1;
            state_nx       = HOLD;
          end
        end else begin
          // The request stays up after a flush; only its data is discarded.
          tmo_cnt_nx = tmo_cnt + 8'd1;
          if (flush) discard_nx = 1'b1;
        end
      end

      HOLD: begin
        if (flush || consume) begin
          instr_valid_nx = 1'b0;
          state_nx       = ISSUE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_addr  <= '0;
      fetch_err   <= 1'b0;
      tmo_cnt     <= '0;
      discard     <= 1'b0;
    end else begin
      state       <= state_nx;
      mem_req     <= mem_req_nx;
      mem_addr    <= mem_addr_nx;
      instr_valid <= instr_valid_nx;
      instr       <= instr_nx;
      instr_addr  <= instr_addr_nx;
      fetch_err   <= fetch_err_nx;
      tmo_cnt     <= tmo_cnt_nx;
      discard     <= discard_nx;
    end
  end

  assign op = instr[15:12];
  assign da = instr[11:8];
  assign aa = instr[7:4];
  assign ba = instr[3:0];

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Stage directly downstream of the program counter.
- Takes the 16-bit instruction address from the PC, runs a req/ack read on instruction memory and holds the returned word in an instruction register.
- Presents the instruction and its fields (OP, DA, AA, BA) to decode/control. AA/BA also feed back into the PC's relative-jump offset.
- Handles variable memory latency, downstream back-pressure, branch flush and a fetch timeout.

Parameters:
- ADDR_W, 16, instruction address width (matches PC output).
- INSTR_W, 16, instruction word width.
- TIMEOUT, 15, max cycles in REQ without mem_ack before a fetch error (1..255).
- NOP_INSTR, 16'h0000, word substituted when a fetch times out.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- instructionAddress  in  ADDR_W  current PC value.
- consume  in  1  decode accepts the held instruction this cycle; PC advances on the same edge.
- flush  in  1  taken jump; discard the held or in-flight instruction.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_ack  in  1  read data valid.
- mem_rdata  in  INSTR_W  read data.
- instr_valid  out  1  instr and fields are valid.
- instr  out  INSTR_W  instruction register.
- op  out  4  instr[15:12].
- da  out  4  instr[11:8].
- aa  out  4  instr[7:4].
- ba  out  4  instr[3:0].
- instr_addr  out  ADDR_W  address the held instruction was fetched from.
- fetch_err  out  1  sticky; set on timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_addr=0, fetch_err=0.
  - Timeout counter=0, discard flag=0.
- States: IDLE, ISSUE, REQ, HOLD. All outputs are registered except op/da/aa/ba, which are slices of instr.
- IDLE: next cycle -> ISSUE.
- ISSUE (1 cycle):
  - Latch instructionAddress into mem_addr; clear the timeout counter and discard flag.
  - -> REQ.
  - This cycle lets a PC update made on the consume/flush edge settle first.
- REQ:
  - mem_req=1; mem_addr held constant until ack.
  - On mem_ack=1 with discard=0: instr<=mem_rdata, instr_addr<=mem_addr, instr_valid<=1, mem_req<=0 -> HOLD.
  - On mem_ack=1 with discard=1: drop the data, mem_req<=0 -> ISSUE.
  - flush=1 in REQ without mem_ack: set discard and keep requesting. An outstanding request is never withdrawn.
  - flush=1 together with mem_ack: data is dropped -> ISSUE.
  - Timeout counter increments each REQ cycle without ack. When it reaches TIMEOUT:
    - mem_req<=0, fetch_err<=1.
    - If discard=1 -> ISSUE.
    - Otherwise instr<=NOP_INSTR, instr_addr<=mem_addr, instr_valid<=1 -> HOLD.
  - A later mem_ack for the timed-out request is ignored; an ack arriving in ISSUE or HOLD has no effect.
- HOLD:
  - instr_valid=1; instr stable.
  - consume=1 -> instr_valid<=0 -> ISSUE.
  - flush=1 -> instr_valid<=0 -> ISSUE.
  - flush and consume in the same cycle: flush wins (identical next state; no double action).
  - Neither asserted: stay in HOLD indefinitely (back-pressure).
- consume or flush while instr_valid=0 is ignored, except flush in REQ as above.
- Latency: memory with ack in the first REQ cycle gives instr_valid 2 cycles after entering ISSUE. Steady-state throughput is one instruction per 3 cycles with zero-wait memory.
- fetch_err clears only on reset.
- Reset mid-REQ deasserts mem_req immediately (asynchronously). The memory must tolerate the abandoned request.

Test Plan:
- Reset release, memory with 0 wait (ack in first REQ cycle), mem[0]=16'h3A57 -> mem_addr=0; instr_valid rises 3 cycles after reset release; op=3, da=A, aa=5, ba=7; instr_addr=0.
- HOLD with consume=0 for 10 cycles, then consume with PC stepped to 1 -> instr constant for 10 cycles; next mem_addr=1, latched in ISSUE.
- Memory with 4 wait cycles, flush asserted in the 2nd REQ cycle, PC jumps to 16'h0040 -> first ack data not presented (instr_valid stays 0); next request has mem_addr=16'h0040.
- flush and consume both high in HOLD -> exactly one ISSUE; instr_valid low the next cycle; no duplicate request.
- Memory never acks with TIMEOUT=15 -> mem_req high for 15 cycles, then low; fetch_err=1; instr=16'h0000 with instr_valid=1; fetch_err stays 1 after later consumes.
- reset pulled low while in REQ -> mem_req=0 and instr_valid=0 without a clock edge; after release, fetch restarts from IDLE with fetch_err=0.
